// File: rtl/adder4_serial_ctrl_pkg.sv
// rtl/adder4_serial_ctrl_pkg.sv - shared constants for the nibble-serial adder
package adder4_serial_ctrl_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/adder4_serial_ctrl_adder4c.sv
// rtl/adder4_serial_ctrl_adder4c.sv - combinational 4-bit adder slice with carry-in
module adder4c
  import adder4_serial_ctrl_pkg::*;
(
  input  logic [NIB_W-1:0] in_data1,
  input  logic [NIB_W-1:0] in_data2,
  input  logic             cin,
  output logic [NIB_W-1:0] out_data,
  output logic             cy
);

  assign {cy, out_data} = {1'b0, in_data1} + {1'b0, in_data2} + {{NIB_W{1'b0}}, cin};

endmodule

// File: rtl/adder4_serial_ctrl.sv
// rtl/adder4_serial_ctrl.sv - wide add sequenced through one 4-bit slice, LS nibble first
module adder4_serial_ctrl
  import adder4_serial_ctrl_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [NIB_W*NIBBLES-1:0] in_data1,
  input  logic [NIB_W*NIBBLES-1:0] in_data2,
  input  logic                     cin,
  output logic [NIB_W*NIBBLES-1:0] out_data,
  output logic                     cy,
  output logic                     busy,
  output logic                     done
);

  localparam int W     = NIB_W * NIBBLES;
  localparam int CNT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  state_t             state;
  logic [W-1:0]       op_a;
  logic [W-1:0]       op_b;
  logic [W-1:0]       psum;
  logic [W-1:0]       psum_next;
  logic               carry;
  logic [CNT_W-1:0]   cnt;
  logic [NIB_W-1:0]   slice_sum;
  logic               slice_cy;

  adder4c u_slice (
    .in_data1 (op_a[NIB_W-1:0]),
    .in_data2 (op_b[NIB_W-1:0]),
    .cin      (carry),
    .out_data (slice_sum),
    .cy       (slice_cy)
  );

  // New nibble enters at the top; after NIBBLES steps nibble 0 has reached the bottom.
  generate
    if (NIBBLES == 1) begin : g_single
      assign psum_next = slice_sum;
    end else begin : g_multi
      assign psum_next = {slice_sum, psum[W-1:NIB_W]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      op_a     <= '0;
      op_b     <= '0;
      psum     <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      out_data <= '0;
      cy       <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            op_a  <= in_data1;
            op_b  <= in_data2;
            carry <= cin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          psum  <= psum_next;
          op_a  <= op_a >> NIB_W;
          op_b  <= op_b >> NIB_W;
          carry <= slice_cy;
          cnt   <= cnt + 1'b1;
          if (cnt == CNT_W'(NIBBLES - 1)) begin
            out_data <= psum_next;
            cy       <= slice_cy;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= ST_DONE;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder4_serial_ctrl.sv
// tb/tb_adder4_serial_ctrl.sv - scoreboard bench for the nibble-serial adder (NIBBLES=4)
module tb_adder4_serial_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] in_data1;
  logic [15:0] in_data2;
  logic        cin;
  logic [15:0] out_data;
  logic        cy;
  logic        busy;
  logic        done;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          done_count = 0;
  int          cyc = 0;
  logic [16:0] sb_q[$];
  int          done_cyc[$];
  logic [15:0] last_sum = 16'h0000;

  adder4_serial_ctrl #(.NIBBLES(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_data1 (in_data1),
    .in_data2 (in_data2),
    .cin      (cin),
    .out_data (out_data),
    .cy       (cy),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse consumes one scoreboard entry.
  always @(negedge clk) begin
    if (rst === 1'b0 && done === 1'b1) begin
      done_count++;
      done_cyc.push_back(cyc);
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got result %0h expected no done", {cy, out_data});
      end else begin
        check("result", {15'b0, cy, out_data}, {15'b0, sb_q.pop_front()});
      end
    end
  end

  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic c,
                       input logic [15:0] es, input logic ec);
    int  busy_n;
    int  lat;
    bit  seen;
    in_data1 = a;
    in_data2 = b;
    cin      = c;
    sb_q.push_back({ec, es});
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    in_data1 = 16'($urandom);
    in_data2 = 16'($urandom);
    cin      = 1'($urandom);
    busy_n = 0;
    lat    = -1;
    seen   = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        lat  = i;
      end else begin
        if (busy === 1'b1) busy_n++;
        check("hold_during_run", {16'b0, out_data}, {16'b0, last_sum});
      end
    end
    check("done_seen", {31'b0, seen}, 32'd1);
    check("busy_cycles", busy_n, 32'd4);
    check("done_latency", lat, 32'd4);
    last_sum = es;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    rst = 1'b1; start = 1'b0; in_data1 = '0; in_data2 = '0; cin = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_out_data", {16'b0, out_data}, 32'h0);
    check("reset_cy", {31'b0, cy}, 32'h0);
    check("reset_busy", {31'b0, busy}, 32'h0);
    check("reset_done", {31'b0, done}, 32'h0);
    @(posedge clk);
    #1;

    do_op(16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);
    do_op(16'h0006, 16'h0003, 1'b0, 16'h0009, 1'b0);
    do_op(16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0);
    do_op(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);
    do_op(16'h7FFC, 16'h8004, 1'b0, 16'h0000, 1'b1);

    // Start pulsed mid-run with new operands must be ignored.
    base = done_count;
    sb_q.push_back({1'b0, 16'h2345});
    in_data1 = 16'h1234; in_data2 = 16'h1111; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; in_data1 = 16'hAAAA; in_data2 = 16'h5555; cin = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (12) @(negedge clk);
    check("ignored_start_dones", done_count - base, 32'd1);
    check("ignored_start_out", {16'b0, out_data}, 32'h2345);
    @(posedge clk); #1;

    // Start held high: accepted at edges 0, 6, 12.
    done_cyc.delete();
    for (int k = 0; k < 3; k++) sb_q.push_back({1'b0, 16'h0003});
    in_data1 = 16'h0001; in_data2 = 16'h0002; cin = 1'b0; start = 1'b1;
    repeat (13) @(posedge clk);
    #1 start = 1'b0;
    repeat (8) @(negedge clk);
    check("held_done_count", done_cyc.size(), 32'd3);
    if (done_cyc.size() == 3) begin
      check("held_spacing_1", done_cyc[1] - done_cyc[0], 32'd6);
      check("held_spacing_2", done_cyc[2] - done_cyc[1], 32'd6);
    end
    @(posedge clk); #1;

    // Reset during the second RUN cycle discards the operation.
    in_data1 = 16'h00FF; in_data2 = 16'h0001; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_busy", {31'b0, busy}, 32'h0);
    check("midrst_out_data", {16'b0, out_data}, 32'h0);
    check("midrst_cy", {31'b0, cy}, 32'h0);
    base = done_count;
    repeat (10) @(negedge clk);
    check("midrst_no_done", done_count - base, 32'd0);
    check("scoreboard_empty", sb_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish within bound");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/adder4_serial_ctrl.md
Name: adder4_serial_ctrl

Overview:
- Sequencer that performs a W-bit addition, where W = 4*NIBBLES, by running one 4-bit adder slice once per clock.
- Works least-significant nibble first and carries between nibbles through a registered carry flag.
- Uses a start/busy/done handshake.
- Sits between CPU control and the 4-bit adder datapath, so wide adds can share one narrow slice.

Parameters:
- NIBBLES, 4, number of 4-bit slices per operation (>=1); operand width W = 4*NIBBLES.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- in_data1  input  W  operand A, captured on accepted start
- in_data2  input  W  operand B, captured on accepted start
- cin  input  1  carry-in to nibble 0, captured on accepted start
- out_data  output  W  registered sum
- cy  output  1  registered carry-out of the top nibble
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse, result valid

Behaviour:
- Reset (synchronous, active-high): state=IDLE; out_data=0, cy=0, busy=0, done=0; internal operand, partial-sum and carry registers and nibble counter cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - If start=1 at an edge: capture in_data1, in_data2 and cin into operand shift registers and carry reg; cnt<=0; go to RUN.
  - Otherwise stay in IDLE.
- RUN, at each edge:
  - Compute {c,s} = opA[3:0] + opB[3:0] + carry (5-bit result).
  - psum <= {s, psum[W-1:4]}.
  - opA and opB shift right by 4.
  - carry <= c; cnt <= cnt+1.
  - If cnt==NIBBLES-1: go to DONE and load out_data<={s,psum[W-1:4]} and cy<=c on that same edge.
- DONE: done=1 for exactly one cycle; next edge goes to IDLE unconditionally.
- busy: high exactly while the state is RUN, i.e. NIBBLES cycles per operation.
- Latency: start sampled at edge 0 → done high during the cycle after edge NIBBLES.
- Minimum spacing between accepted starts: NIBBLES+2 edges. With NIBBLES=4 and start held high, an operation is accepted every 6 cycles.
- Output hold: out_data and cy hold their last result until the next DONE load. They do not change during RUN, and start acceptance does not clear them.
- Start outside IDLE: ignored in RUN and DONE, including start coincident with done. The in-flight operands are unaffected.
- Inputs after capture: operand or cin changes after the capture edge do not affect the result.
- Arithmetic: unsigned and modulo 2^W. cy is the carry-out of bit W-1; no overflow flag.
- NIBBLES=1: a single RUN cycle; the result equals a direct 4-bit add with cin.
- Reset mid-operation (RUN or DONE): next state IDLE, all outputs 0, no done pulse, the operation is discarded.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - nibble width constant NIB_W=4.
- One sub-module: adder4c, a combinational 4-bit adder with carry-in.
  - Ports: in_data1[3:0], in_data2[3:0], cin, out_data[3:0], cy.
  - Instantiated once, driven from the low nibbles of the operand shift registers.
- Controller FSM, counter and shift registers live in adder4_serial_ctrl.

Test Plan (NIBBLES=4):
- Reset: assert rst for 2 cycles → out_data=0x0000, cy=0, busy=0, done=0.
- Zero add: in_data1=0x0000, in_data2=0x0000, cin=0, start one cycle → busy high exactly 4 cycles; done pulses once, 4 edges after the start edge; out_data=0x0000, cy=0.
- Small add and ripple:
  - 0x0006 + 0x0003, cin=0 → out_data=0x0009, cy=0.
  - Then 0x0F0F + 0x00F1 → out_data=0x1000, cy=0 (carry crosses nibbles 0→1→2).
- Full-scale with carry-in: 0xFFFF + 0xFFFF, cin=1 → out_data=0xFFFF, cy=1. Then 0x7FFC + 0x8004 → 0x0000, cy=1.
- Start and input handling:
  - Start 0x1234+0x1111; during RUN pulse start with 0xAAAA+0x5555 and change the inputs → single done, out_data=0x2345.
  - Start held high continuously → done pulses every 6 cycles.
- Reset mid-operation: start 0x00FF+0x0001, assert rst at the 2nd RUN cycle → next cycle busy=0, out_data=0x0000, cy=0; no done pulse in the following 10 cycles.
